// File: rtl/fx3_capture_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fx3_capture_sequencer_pkg
// Shared definitions for the FX3 capture sequencer:
//   - seq_state_t   : 3-bit FSM state encoding, also exported on seqState
//   - DEFAULT_BURST_WORDS : default words per FX3 transfer
//   - write_window()      : states in which FIFO writes are permitted
// ---------------------------------------------------------------------------
package fx3_capture_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FLUSH     = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_READY     = 3'd3,
      ST_BURST     = 3'd4,
      ST_DRAIN     = 3'd5,
      ST_ERROR     = 3'd6
   } seq_state_t;

   localparam int DEFAULT_BURST_WORDS = 8192;

   // Samples are only kept while a session is live and no error is latched.
   function automatic logic write_window(input seq_state_t s);
      return (s inside {ST_WAIT_DATA, ST_READY, ST_BURST, ST_DRAIN});
   endfunction

endpackage

// File: rtl/fx3_capture_sequencer_burst_word_counter.sv
// ---------------------------------------------------------------------------
// burst_word_counter
// Down-counter for the words remaining in a burst.
//   i_clk, i_rst_n : clock and synchronous active-low reset
//   i_load         : load i_load_value (has priority over decrement)
//   i_load_value   : value to load, normally BURST_WORDS-1
//   i_decrement    : count down by one, holds at zero
//   o_terminal     : count is zero (the current pop is the last one)
// ---------------------------------------------------------------------------
module burst_word_counter #(
   parameter int WIDTH = 13
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_decrement,
   output logic             o_terminal
);

   logic [WIDTH-1:0] r_count;

   // NOTE: reset is sampled on the clock edge here (synchronous), so it sits
   // inside the clocked branch rather than in the sensitivity list.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_decrement && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_terminal = (r_count == '0);

endmodule

// File: rtl/fx3_capture_sequencer.sv
// ---------------------------------------------------------------------------
// fx3_capture_sequencer
// Sequences capture sessions between the FX3 GPIF handshake and the sample
// FIFO, all in the FX3 clock domain.
//   clock, nReset   : FX3 clock, synchronous active-low reset
//   collectData     : host capture enable (level)
//   readData        : FX3 read strobe, high for a whole burst
//   fifoLevel       : FIFO read-side fill level in words
//   fifoOverflow    : FIFO write overflow pulse
//   flushDone       : FIFO flush complete pulse
//   flushRequest    : clear FIFO contents
//   writeEnable     : permit FIFO writes
//   fifoReadEnable  : pop one word per cycle during a burst
//   dataAvailable   : a full burst is buffered
//   bufferError     : sticky overflow / aborted-burst flag
//   burstCount      : completed bursts, wraps
//   seqState        : current state encoding (debug)
// ---------------------------------------------------------------------------
module fx3_capture_sequencer
   import fx3_capture_sequencer_pkg::*;
#(
   parameter int BURST_WORDS = DEFAULT_BURST_WORDS,
   parameter int LEVEL_W     = 16,
   parameter int CNT_W       = 16
) (
   input  logic               clock,
   input  logic               nReset,
   input  logic               collectData,
   input  logic               readData,
   input  logic [LEVEL_W-1:0] fifoLevel,
   input  logic               fifoOverflow,
   input  logic               flushDone,
   output logic               flushRequest,
   output logic               writeEnable,
   output logic               fifoReadEnable,
   output logic               dataAvailable,
   output logic               bufferError,
   output logic [CNT_W-1:0]   burstCount,
   output logic [2:0]         seqState
);

   localparam int WC_W = $clog2(BURST_WORDS);

   seq_state_t       r_state;
   seq_state_t       w_next_state;
   logic             r_collect_prev;
   logic             r_flush_request;
   logic             r_write_enable;
   logic             r_data_available;
   logic             r_buffer_error;
   logic [CNT_W-1:0] r_burst_count;

   logic w_capture_start;
   logic w_overflow;
   logic w_terminal;
   logic w_burst_done;
   logic w_level_ok;
   logic w_load;

   assign w_capture_start = collectData & ~r_collect_prev;
   // r_write_enable mirrors the current state, so this masks overflow
   // pulses outside an active capture window.
   assign w_overflow      = fifoOverflow & r_write_enable;
   assign w_level_ok      = (fifoLevel >= LEVEL_W'(BURST_WORDS));
   assign w_burst_done    = (r_state == ST_BURST) & w_terminal;
   assign w_load          = (r_state == ST_READY) & (w_next_state == ST_BURST);

   burst_word_counter #(
      .WIDTH (WC_W)
   ) u_word_counter (
      .i_clk        (clock),
      .i_rst_n      (nReset),
      .i_load       (w_load),
      .i_load_value (WC_W'(BURST_WORDS - 1)),
      .i_decrement  (r_state == ST_BURST),
      .o_terminal   (w_terminal)
   );

   // NOTE: the default assignment first keeps every path driven, so no
   // latch is inferred for w_next_state.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (w_capture_start) w_next_state = ST_FLUSH;
         ST_FLUSH:     if (!collectData)    w_next_state = ST_IDLE;
                       else if (flushDone)  w_next_state = ST_WAIT_DATA;
         ST_WAIT_DATA: if (!collectData)    w_next_state = ST_IDLE;
                       else if (w_level_ok) w_next_state = ST_READY;
         ST_READY:     if (readData)        w_next_state = ST_BURST;
                       else if (!collectData) w_next_state = ST_IDLE;
         // The terminal pop completes the burst even if readData is already
         // low; collectData is deliberately ignored here.
         ST_BURST:     if (w_terminal)      w_next_state = ST_DRAIN;
                       else if (!readData)  w_next_state = ST_ERROR;
         ST_DRAIN:     if (!readData)
                          w_next_state = collectData ? ST_WAIT_DATA : ST_IDLE;
         ST_ERROR:     if (!collectData)    w_next_state = ST_IDLE;
         default:                           w_next_state = ST_IDLE;
      endcase
      // Overflow beats every other transition, including DRAIN.
      if (w_overflow) w_next_state = ST_ERROR;
   end

   // Outputs are decoded from the next state so they are registered yet
   // line up with seqState in the same cycle.
   // NOTE: non-blocking assignments throughout, so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (!nReset) begin
         r_state          <= ST_IDLE;
         r_collect_prev   <= 1'b0;
         r_flush_request  <= 1'b0;
         r_write_enable   <= 1'b0;
         r_data_available <= 1'b0;
         r_buffer_error   <= 1'b0;
         r_burst_count    <= '0;
      end else begin
         r_state          <= w_next_state;
         r_collect_prev   <= collectData;
         r_flush_request  <= (w_next_state == ST_FLUSH);
         r_write_enable   <= write_window(w_next_state);
         r_data_available <= (w_next_state == ST_READY);
         if ((r_state == ST_IDLE) && w_capture_start) begin
            r_buffer_error <= 1'b0;
            r_burst_count  <= '0;
         end else begin
            if (w_next_state == ST_ERROR) r_buffer_error <= 1'b1;
            if (w_burst_done)             r_burst_count  <= r_burst_count + 1'b1;
         end
      end
   end

   assign flushRequest   = r_flush_request;
   assign writeEnable    = r_write_enable;
   assign dataAvailable  = r_data_available;
   assign bufferError    = r_buffer_error;
   assign burstCount     = r_burst_count;
   assign seqState       = r_state;
   assign fifoReadEnable = (r_state == ST_BURST);

endmodule

// File: tb/tb_fx3_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fx3_capture_sequencer
// Directed bench for fx3_capture_sequencer with BURST_WORDS=16. A second
// instance with CNT_W=2 shares all inputs to exercise burstCount wrap.
// ---------------------------------------------------------------------------
module tb_fx3_capture_sequencer;

   localparam int BW = 16;

   logic        clock = 1'b0;
   logic        nReset = 1'b0;
   logic        collectData = 1'b0;
   logic        readData = 1'b0;
   logic [15:0] fifoLevel = '0;
   logic        fifoOverflow = 1'b0;
   logic        flushDone = 1'b0;

   logic        flushRequest, writeEnable, fifoReadEnable, dataAvailable, bufferError;
   logic [15:0] burstCount;
   logic [2:0]  seqState;

   logic        b_flushRequest, b_writeEnable, b_fifoReadEnable, b_dataAvailable, b_bufferError;
   logic [1:0]  b_burstCount;
   logic [2:0]  b_seqState;

   int n_checks = 0;
   int n_errors = 0;
   int pops;

   always #5 clock = ~clock;

   fx3_capture_sequencer #(.BURST_WORDS(BW), .LEVEL_W(16), .CNT_W(16)) dut (
      .clock(clock), .nReset(nReset), .collectData(collectData), .readData(readData),
      .fifoLevel(fifoLevel), .fifoOverflow(fifoOverflow), .flushDone(flushDone),
      .flushRequest(flushRequest), .writeEnable(writeEnable),
      .fifoReadEnable(fifoReadEnable), .dataAvailable(dataAvailable),
      .bufferError(bufferError), .burstCount(burstCount), .seqState(seqState)
   );

   fx3_capture_sequencer #(.BURST_WORDS(BW), .LEVEL_W(16), .CNT_W(2)) dut_wrap (
      .clock(clock), .nReset(nReset), .collectData(collectData), .readData(readData),
      .fifoLevel(fifoLevel), .fifoOverflow(fifoOverflow), .flushDone(flushDone),
      .flushRequest(b_flushRequest), .writeEnable(b_writeEnable),
      .fifoReadEnable(b_fifoReadEnable), .dataAvailable(b_dataAvailable),
      .bufferError(b_bufferError), .burstCount(b_burstCount), .seqState(b_seqState)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then stable and inputs may be changed.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Pop-counting advance: step until pops reaches target (bounded).
   task automatic pop_until(input int target);
      for (int i = 0; i < 40 && pops < target; i++) begin
         step();
         if (fifoReadEnable) pops++;
      end
   endtask

   // From IDLE or ERROR: fresh capture start, flush, and reach READY
   // (fifoLevel must already be >= BW).
   task automatic start_session(input string tag);
      collectData = 1'b0; step();
      collectData = 1'b1; step();
      flushDone = 1'b1;   step();
      flushDone = 1'b0;   step();
      check({tag, "_ready"}, seqState, 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset for 4 cycles
      repeat (4) step();
      check("rst_state", seqState, 0);
      check("rst_outs", {flushRequest, writeEnable, fifoReadEnable, dataAvailable, bufferError}, 0);
      check("rst_count", burstCount, 0);
      nReset = 1'b1;
      step();
      check("idle_hold", seqState, 0);

      // Start: flushRequest cycles 1..5, flushDone in cycle 5
      collectData = 1'b1;
      step();
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("flush_req_c%0d", c), flushRequest, 1);
         check($sformatf("flush_we_c%0d", c), writeEnable, 0);
         if (c == 5) flushDone = 1'b1;
         step();
         flushDone = 1'b0;
      end
      check("wait_we", writeEnable, 1);
      check("wait_state", seqState, 2);
      check("wait_flush_off", flushRequest, 0);
      check("wait_count", burstCount, 0);
      check("wait_err", bufferError, 0);

      // Level ramp
      fifoLevel = 16'd12; step();
      check("lvl12_state", seqState, 2);
      check("lvl12_da", dataAvailable, 0);
      fifoLevel = 16'd16; step();
      check("lvl16_state", seqState, 3);
      check("lvl16_da", dataAvailable, 1);

      // Normal burst: readData high 20 cycles
      readData = 1'b1;
      pops = 0;
      step();
      check("burst_first_pop", fifoReadEnable, 1);
      check("burst_da", dataAvailable, 0);
      if (fifoReadEnable) pops++;
      for (int i = 1; i < 20; i++) begin
         step();
         if (fifoReadEnable) pops++;
      end
      check("burst_pops", pops, 16);
      check("burst_drain", seqState, 5);
      check("burst_count", burstCount, 1);
      readData = 1'b0; step();
      check("drain_to_wait", seqState, 2);

      // Aborted burst after 9 pops
      step();
      check("abort_ready", seqState, 3);
      readData = 1'b1; pops = 0;
      pop_until(9);
      readData = 1'b0; step();
      check("abort_state", seqState, 6);
      check("abort_err", bufferError, 1);
      check("abort_count", burstCount, 1);
      check("abort_no_pop", fifoReadEnable, 0);
      check("abort_we", writeEnable, 0);
      collectData = 1'b0; step();
      check("abort_idle", seqState, 0);
      check("abort_err_held", bufferError, 1);
      collectData = 1'b1; step();
      check("restart_flush", seqState, 1);
      check("restart_err_clr", bufferError, 0);
      check("restart_cnt_clr", burstCount, 0);

      // Overflow in WAIT_DATA
      fifoLevel = 16'd0;
      flushDone = 1'b1; step();
      flushDone = 1'b0;
      check("ovf_wait", seqState, 2);
      fifoOverflow = 1'b1; step();
      fifoOverflow = 1'b0;
      check("ovf_we", writeEnable, 0);
      check("ovf_err", bufferError, 1);
      check("ovf_state", seqState, 6);
      check("ovf_da", dataAvailable, 0);

      // Overflow coinciding with the 16th pop
      fifoLevel = 16'd16;
      start_session("ovf16");
      readData = 1'b1; pops = 0;
      pop_until(16);
      fifoOverflow = 1'b1; step();
      fifoOverflow = 1'b0; readData = 1'b0;
      check("ovf16_pops", pops, 16);
      check("ovf16_state", seqState, 6);
      check("ovf16_count", burstCount, 1);
      check("ovf16_err", bufferError, 1);

      // collectData falls at pop 5: burst still completes
      start_session("stop");
      readData = 1'b1; pops = 0;
      pop_until(5);
      collectData = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (fifoReadEnable) pops++;
      end
      check("stop_pops", pops, 16);
      check("stop_drain", seqState, 5);
      check("stop_count", burstCount, 1);
      readData = 1'b0; step();
      check("stop_idle", seqState, 0);
      check("stop_we", writeEnable, 0);

      // Reset at pop 7
      start_session("rstmid");
      readData = 1'b1; pops = 0;
      pop_until(7);
      check("rstmid_pops", pops, 7);
      nReset = 1'b0; step();
      check("rstmid_state", seqState, 0);
      check("rstmid_outs", {flushRequest, writeEnable, fifoReadEnable, dataAvailable, bufferError}, 0);
      check("rstmid_count", burstCount, 0);
      check("rstmid_wrap_count", b_burstCount, 0);
      nReset = 1'b1; readData = 1'b0;

      // Five back-to-back bursts: CNT_W=16 reads 5, CNT_W=2 wraps to 1
      start_session("wrap");
      pops = 0;
      for (int b = 0; b < 5; b++) begin
         readData = 1'b1;
         for (int i = 0; i < 17; i++) begin
            step();
            if (fifoReadEnable) pops++;
         end
         readData = 1'b0; step();
         step();
      end
      check("wrap_pops", pops, 80);
      check("wrap_state", seqState, 3);
      check("wrap_count16", burstCount, 5);
      check("wrap_count2", b_burstCount, 1);
      check("wrap_err", bufferError, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fx3_capture_sequencer.md
Name: fx3_capture_sequencer

Overview:
Sequences capture sessions between the FX3 GPIF handshake and the sample FIFO, in the FX3 clock domain.
- Arms and flushes the FIFO when the host starts collection.
- Gates FIFO writes and advertises a full burst to the FX3.
- Issues exactly one burst of FIFO reads per FX3 read request.
- Latches overflow and burst-abort errors and counts completed bursts for status reporting.

Parameters:
BURST_WORDS, 8192, words per FX3 transfer; power of two, >= 4
LEVEL_W, 16, width of FIFO fill-level input; 2^LEVEL_W > BURST_WORDS
CNT_W, 16, width of completed-burst counter

Ports:
clock  in  1  FX3 clock, 60 MHz
nReset  in  1  synchronous active-low reset
collectData  in  1  FX3 capture enable; level, synchronous to clock
readData  in  1  FX3 read strobe; held high for the whole burst
fifoLevel  in  LEVEL_W  FIFO read-side fill level in words
fifoOverflow  in  1  one-cycle pulse, FIFO write overflow (already in clock domain)
flushDone  in  1  FIFO flush complete, one-cycle pulse
flushRequest  out  1  clear FIFO contents
writeEnable  out  1  permit FIFO writes
fifoReadEnable  out  1  pop one word per cycle
dataAvailable  out  1  to FX3: a full burst is buffered
bufferError  out  1  sticky error flag to FX3
burstCount  out  CNT_W  completed bursts, wraps
seqState  out  3  current state encoding, debug

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-burst has the same result on the next edge; no partial burst is completed.
- All outputs are registered. fifoReadEnable is combinational from state and counter only.
- States: IDLE=0, FLUSH=1, WAIT_DATA=2, READY=3, BURST=4, DRAIN=5, ERROR=6.
- IDLE:
  - All outputs 0 except burstCount and bufferError.
  - A rising edge of collectData (registered previous value 0, current 1) goes to FLUSH.
  - On that edge, bufferError clears and burstCount clears.
- FLUSH:
  - flushRequest=1 until flushDone.
  - On flushDone, go to WAIT_DATA.
  - If collectData falls, go to IDLE.
- WAIT_DATA:
  - writeEnable=1.
  - fifoLevel >= BURST_WORDS goes to READY.
  - collectData=0 goes to IDLE.
- READY:
  - writeEnable=1, dataAvailable=1.
  - readData=1 goes to BURST and loads the word counter with BURST_WORDS-1.
  - collectData=0 (with readData=0) goes to IDLE.
- BURST:
  - fifoReadEnable=1 every cycle.
  - Counter decrements each cycle.
  - First pop occurs the cycle after readData is sampled high (1-cycle latency); exactly BURST_WORDS pops total.
  - dataAvailable=0 throughout.
  - When the counter is 0 and pops, burstCount increments (mod 2^CNT_W) and state goes to DRAIN.
  - readData falls before the final pop: go to ERROR, set bufferError, no burstCount increment.
  - collectData falling during BURST is ignored until the burst ends.
- DRAIN:
  - Wait for readData=0.
  - Then go to WAIT_DATA if collectData=1, else IDLE.
  - The level check resumes in WAIT_DATA, so back-to-back bursts need ≥2 idle cycles.
- Overflow:
  - fifoOverflow=1 in any state with writeEnable=1 goes to ERROR next cycle.
  - bufferError=1, writeEnable=0, dataAvailable=0, fifoReadEnable=0.
  - If it coincides with the final pop, burstCount still increments and ERROR wins over DRAIN.
- ERROR:
  - bufferError stays held.
  - collectData=0 goes to IDLE; bufferError remains set until the next capture start.
- writeEnable stays 0 in IDLE, FLUSH and ERROR. Samples arriving then are discarded by the FIFO.
- fifoLevel below BURST_WORDS during BURST (underflow) is not checked; the FIFO guarantees it by the READY entry condition.

Decomposition:
- Shared package holds:
  - state encoding constants (3-bit, values above);
  - default BURST_WORDS.
- One sub-module: burst_word_counter.
  - Ports: load, decrement, terminal flag.
  - Width is clog2(BURST_WORDS).
  - Reusable for future multi-burst modes.
- The rest is a single FSM plus the burstCount register.

Test Plan:
- Reset and start: nReset low 4 cycles, then collectData 0→1, flushDone pulse at cycle 5 → flushRequest high cycles 1–5, writeEnable rises the cycle after flushDone, burstCount=0, bufferError=0.
- Normal burst (BURST_WORDS=16 build): fifoLevel ramps to 16 → dataAvailable=1. readData high 20 cycles → exactly 16 fifoReadEnable cycles, starting the cycle after readData. burstCount=1. DRAIN until readData low, then WAIT_DATA.
- Aborted burst: readData drops after 9 pops → ERROR, bufferError=1, burstCount unchanged. collectData 0 → IDLE with bufferError still 1. Next collectData rise clears it.
- Overflow: fifoOverflow pulse while in WAIT_DATA → next cycle writeEnable=0, bufferError=1, seqState=6. Overflow coinciding with the 16th pop → burstCount increments and state is ERROR.
- Stop mid-burst: collectData falls at pop 5 → all 16 pops still occur, then DRAIN → IDLE, writeEnable=0.
- Reset mid-burst: nReset low at pop 7 → next edge all outputs 0, seqState=0, burstCount=0. Wrap check: CNT_W=2 build with 5 bursts → burstCount=1.
